// File: rtl/cam_seq_pkg.sv
// Shared types for the CAM subarray command sequencer.
//   OP_* : micro-command opcodes understood by the subarray.
//   seq_state_e : sequencer FSM states.
//   cam_cmd_t : one queued command, all cmd_* fields packed together.
//   op_legal() : true for the three opcodes the subarray understands.
package cam_seq_pkg;

  localparam logic [2:0] OP_WRITE  = 3'b000;
  localparam logic [2:0] OP_UPDATE = 3'b001;
  localparam logic [2:0] OP_SEARCH = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_WR,
    ST_CAPTURE,
    ST_RESP
  } seq_state_e;

  typedef struct packed {
    logic [2:0]  op;
    logic        acc;
    logic        chain;
    logic        addr_sel;
    logic [9:0]  cmp_addr;
    logic [3:0]  ppg_addr;
    logic [1:0]  cmp_data;
    logic [1:0]  ppg_data;
    logic [15:0] data;
    logic [15:0] tag;
  } cam_cmd_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_WRITE) || (op == OP_UPDATE) || (op == OP_SEARCH);
  endfunction

endpackage

// File: rtl/cam_subarray_seq_if.sv
// Command / response handshake bundle of the CAM sequencer.
//   master : command producer / response consumer
//   slave  : the sequencer
interface cam_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic        cmd_acc;
  logic        cmd_chain;
  logic        cmd_addr_sel;
  logic [9:0]  cmd_cmp_addr;
  logic [3:0]  cmd_ppg_addr;
  logic [1:0]  cmd_cmp_data;
  logic [1:0]  cmd_ppg_data;
  logic [15:0] cmd_data;
  logic [15:0] cmd_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_tag;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_acc, cmd_chain, cmd_addr_sel, cmd_cmp_addr,
           cmd_ppg_addr, cmd_cmp_data, cmd_ppg_data, cmd_data, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_tag, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_acc, cmd_chain, cmd_addr_sel, cmd_cmp_addr,
           cmd_ppg_addr, cmd_cmp_data, cmd_ppg_data, cmd_data, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_tag, rsp_err
  );
endinterface

// File: rtl/cam_cmd_fifo.sv
// Synchronous FIFO of cam_cmd_t, DEPTH entries (power of 2).
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   push/wr_data, pop/rd_data : first-word-fall-through access
//   full, empty : occupancy flags
module cam_cmd_fifo
  import cam_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  cam_cmd_t wr_data,
  input  logic     pop,
  output cam_cmd_t rd_data,
  output logic     full,
  output logic     empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  cam_cmd_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  // a pop frees the slot the same cycle, so push-while-full is legal then
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // pointers are exactly log2(DEPTH) wide, so they wrap on their own
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/cam_subarray_seq.sv
// Command sequencer for one CAM subarray.
//   CLK, rst   : clock, async active-low reset
//   bus        : cmd valid/ready in, one rsp valid/ready out per command
//   busy       : FSM active or commands queued
//   cam_*      : registered control/data pins to the subarray,
//                cam_tag_out / cam_write_done back from it
// Flow: IDLE pops a command and launches it straight onto the pins
// (ISSUE), writes then wait for cam_write_done with a timeout, searches
// take one CAPTURE cycle and latch the tag, then RESP holds the
// response until it is taken. Illegal ops skip to RESP with err set.
module cam_subarray_seq
  import cam_seq_pkg::*;
#(
  parameter int CMD_DEPTH  = 4,
  parameter int WR_TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        rst,
  cam_seq_if.slave    bus,
  output logic        busy,
  output logic [15:0] cam_data_in,
  output logic        cam_update_signal,
  output logic [9:0]  cam_cmp_addr,
  output logic [3:0]  cam_ppg_addr,
  output logic [1:0]  cam_cmp_data,
  output logic [1:0]  cam_ppg_data,
  output logic [15:0] cam_tag_in,
  output logic        cam_addr_select,
  output logic [2:0]  cam_operation_mode,
  output logic        cam_chip_enable,
  output logic        cam_acc_en,
  input  logic [15:0] cam_tag_out,
  input  logic        cam_write_done
);
  localparam int CW = (WR_TIMEOUT > 0) ? $clog2(WR_TIMEOUT + 1) : 1;

  cam_cmd_t    push_cmd, head;
  logic        full, empty, push, pop, rdy_en;
  seq_state_e  state;
  logic [CW-1:0] wr_cnt;
  logic [15:0] last_tag;
  logic [2:0]  cur_op;
  logic        rsp_valid_q, rsp_err_q;
  logic [15:0] rsp_tag_q;

  always_comb begin
    push_cmd          = '0;
    push_cmd.op       = bus.cmd_op;
    push_cmd.acc      = bus.cmd_acc;
    push_cmd.chain    = bus.cmd_chain;
    push_cmd.addr_sel = bus.cmd_addr_sel;
    push_cmd.cmp_addr = bus.cmd_cmp_addr;
    push_cmd.ppg_addr = bus.cmd_ppg_addr;
    push_cmd.cmp_data = bus.cmd_cmp_data;
    push_cmd.ppg_data = bus.cmd_ppg_data;
    push_cmd.data     = bus.cmd_data;
    push_cmd.tag      = bus.cmd_tag;
  end

  // cmd_ready is held low through reset and the first edge after it
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) rdy_en <= 1'b0;
    else      rdy_en <= 1'b1;
  end

  assign bus.cmd_ready = rdy_en & ~full;
  assign push          = bus.cmd_valid & bus.cmd_ready;
  assign pop           = (state == ST_IDLE) & ~empty;
  assign busy          = (state != ST_IDLE) | ~empty;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_tag   = rsp_tag_q;
  assign bus.rsp_err   = rsp_err_q;

  cam_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
    .clk     (CLK),
    .rst_n   (rst),
    .push    (push),
    .wr_data (push_cmd),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state              <= ST_IDLE;
      wr_cnt             <= '0;
      last_tag           <= '0;
      cur_op             <= '0;
      rsp_valid_q        <= 1'b0;
      rsp_err_q          <= 1'b0;
      rsp_tag_q          <= '0;
      cam_data_in        <= '0;
      cam_update_signal  <= 1'b0;
      cam_cmp_addr       <= '0;
      cam_ppg_addr       <= '0;
      cam_cmp_data       <= '0;
      cam_ppg_data       <= '0;
      cam_tag_in         <= '0;
      cam_addr_select    <= 1'b0;
      cam_operation_mode <= '0;
      cam_chip_enable    <= 1'b0;
      cam_acc_en         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (!empty) begin
          cur_op <= head.op;
          if (op_legal(head.op)) begin
            // pins are registered, so they are live for the whole ISSUE cycle
            state              <= ST_ISSUE;
            cam_chip_enable    <= 1'b1;
            cam_operation_mode <= head.op;
            cam_data_in        <= head.data;
            cam_cmp_addr       <= head.cmp_addr;
            cam_ppg_addr       <= head.ppg_addr;
            cam_cmp_data       <= head.cmp_data;
            cam_ppg_data       <= head.ppg_data;
            cam_addr_select    <= head.addr_sel;
            cam_update_signal  <= (head.op == OP_UPDATE);
            cam_tag_in         <= head.chain ? last_tag : head.tag;
            cam_acc_en         <= (head.op == OP_SEARCH) & head.acc;
          end else begin
            state       <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_tag_q   <= '0;
          end
        end
        ST_ISSUE: begin
          wr_cnt <= '0;
          state  <= (cur_op == OP_SEARCH) ? ST_CAPTURE : ST_WAIT_WR;
        end
        ST_WAIT_WR: begin
          if (cam_write_done || (wr_cnt == CW'(WR_TIMEOUT))) begin
            state           <= ST_RESP;
            rsp_valid_q     <= 1'b1;
            rsp_err_q       <= ~cam_write_done;
            rsp_tag_q       <= '0;
            cam_chip_enable <= 1'b0;
            cam_acc_en      <= 1'b0;
          end else begin
            wr_cnt <= wr_cnt + CW'(1);
          end
        end
        ST_CAPTURE: begin
          state           <= ST_RESP;
          last_tag        <= cam_tag_out;
          rsp_tag_q       <= cam_tag_out;
          rsp_err_q       <= 1'b0;
          rsp_valid_q     <= 1'b1;
          cam_chip_enable <= 1'b0;
          cam_acc_en      <= 1'b0;
        end
        ST_RESP: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cam_subarray_seq.sv
// Directed bench for cam_subarray_seq: reset, write, search/chain/acc,
// write timeout, illegal op, full-queue ordering and mid-write reset.
module tb_cam_subarray_seq;
  logic        CLK = 1'b0;
  logic        rst;
  logic        busy;
  logic [15:0] cam_data_in;
  logic        cam_update_signal;
  logic [9:0]  cam_cmp_addr;
  logic [3:0]  cam_ppg_addr;
  logic [1:0]  cam_cmp_data;
  logic [1:0]  cam_ppg_data;
  logic [15:0] cam_tag_in;
  logic        cam_addr_select;
  logic [2:0]  cam_operation_mode;
  logic        cam_chip_enable;
  logic        cam_acc_en;
  logic [15:0] cam_tag_out;
  logic        cam_write_done;
  logic        tag_mode;
  logic [15:0] tag_drv;
  int          n_checks = 0;
  int          n_pass   = 0;

  cam_seq_if bus ();

  cam_subarray_seq #(.CMD_DEPTH(4), .WR_TIMEOUT(15)) dut (
    .CLK                (CLK),
    .rst                (rst),
    .bus                (bus),
    .busy               (busy),
    .cam_data_in        (cam_data_in),
    .cam_update_signal  (cam_update_signal),
    .cam_cmp_addr       (cam_cmp_addr),
    .cam_ppg_addr       (cam_ppg_addr),
    .cam_cmp_data       (cam_cmp_data),
    .cam_ppg_data       (cam_ppg_data),
    .cam_tag_in         (cam_tag_in),
    .cam_addr_select    (cam_addr_select),
    .cam_operation_mode (cam_operation_mode),
    .cam_chip_enable    (cam_chip_enable),
    .cam_acc_en         (cam_acc_en),
    .cam_tag_out        (cam_tag_out),
    .cam_write_done     (cam_write_done)
  );

  always #5 CLK = ~CLK;

  // subarray stand-in: either a fixed tag or a tag equal to the compare address
  assign cam_tag_out = tag_mode ? {6'd0, cam_cmp_addr} : tag_drv;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic send(input logic [2:0] op, input logic acc, input logic chain,
                      input logic asel, input logic [9:0] ca, input logic [3:0] pa,
                      input logic [1:0] cd, input logic [1:0] pd,
                      input logic [15:0] d, input logic [15:0] t);
    bus.cmd_op       = op;
    bus.cmd_acc      = acc;
    bus.cmd_chain    = chain;
    bus.cmd_addr_sel = asel;
    bus.cmd_cmp_addr = ca;
    bus.cmd_ppg_addr = pa;
    bus.cmd_cmp_data = cd;
    bus.cmd_ppg_data = pd;
    bus.cmd_data     = d;
    bus.cmd_tag      = t;
    bus.cmd_valid    = 1'b1;
    chk("send_ready", 32'(bus.cmd_ready), 1);
    step();
    bus.cmd_valid    = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    tag_mode = 1'b0;
    tag_drv = 16'h0;
    cam_write_done = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 3'd2; bus.cmd_acc = 1'b0; bus.cmd_chain = 1'b0; bus.cmd_addr_sel = 1'b1;
    bus.cmd_cmp_addr = 10'h3FF; bus.cmd_ppg_addr = 4'hF; bus.cmd_cmp_data = 2'd3;
    bus.cmd_ppg_data = 2'd3; bus.cmd_data = 16'hFFFF; bus.cmd_tag = 16'hFFFF;

    // reset with cmd_valid high: nothing accepted, everything low
    repeat (3) step();
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_busy",      32'(busy), 0);
    chk("rst_ce",        32'(cam_chip_enable), 0);
    chk("rst_upd",       32'(cam_update_signal), 0);
    chk("rst_pins",      32'({cam_data_in, cam_tag_in}), 0);
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rdy_before_edge", 32'(bus.cmd_ready), 0);
    step();
    chk("rdy_after_edge", 32'(bus.cmd_ready), 1);
    chk("rel_busy",       32'(busy), 0);

    // direct write, done after two idle WAIT_WR cycles; done in ISSUE ignored
    bus.rsp_ready = 1'b1;
    send(3'd0, 1'b1, 1'b0, 1'b1, 10'h155, 4'h3, 2'd2, 2'd1, 16'hFFFF, 16'h1234);
    chk("wr_busy", 32'(busy), 1);
    chk("wr_ce_e0", 32'(cam_chip_enable), 0);
    step();
    chk("wr_iss_ce",   32'(cam_chip_enable), 1);
    chk("wr_iss_mode", 32'(cam_operation_mode), 0);
    chk("wr_iss_data", 32'(cam_data_in), 'hFFFF);
    chk("wr_iss_asel", 32'(cam_addr_select), 1);
    chk("wr_iss_addr", 32'({cam_cmp_addr, cam_ppg_addr, cam_cmp_data, cam_ppg_data}), 'h1553_9);
    chk("wr_iss_upd",  32'(cam_update_signal), 0);
    chk("wr_iss_acc",  32'(cam_acc_en), 0);
    chk("wr_iss_tag",  32'(cam_tag_in), 'h1234);
    cam_write_done = 1'b1;
    step();
    chk("wr_done_in_issue", 32'(bus.rsp_valid), 0);
    cam_write_done = 1'b0;
    step();
    chk("wr_wait1_valid", 32'(bus.rsp_valid), 0);
    step();
    chk("wr_wait2_ce",   32'(cam_chip_enable), 1);
    chk("wr_wait2_data", 32'(cam_data_in), 'hFFFF);
    cam_write_done = 1'b1;
    step();
    chk("wr_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("wr_rsp_err",   32'(bus.rsp_err), 0);
    chk("wr_rsp_tag",   32'(bus.rsp_tag), 0);
    chk("wr_rsp_ce",    32'(cam_chip_enable), 0);
    chk("wr_rsp_hold",  32'({cam_data_in, cam_addr_select}), 'h1FFFF);
    cam_write_done = 1'b0;
    step();
    chk("wr_done_valid", 32'(bus.rsp_valid), 0);
    chk("wr_done_busy",  32'(busy), 0);

    // search: response 3 edges after accept, held while rsp_ready low
    bus.rsp_ready = 1'b0;
    tag_drv = 16'hAAAA;
    send(3'd2, 1'b0, 1'b0, 1'b0, 10'b00001_00000, 4'h0, 2'd1, 2'd0, 16'h0, 16'h0F0F);
    step();
    chk("s1_mode", 32'(cam_operation_mode), 2);
    chk("s1_tagin", 32'(cam_tag_in), 'h0F0F);
    chk("s1_acc", 32'(cam_acc_en), 0);
    chk("s1_addr", 32'({cam_cmp_addr, cam_cmp_data}), 'h81);
    step();
    chk("s1_capture_valid", 32'(bus.rsp_valid), 0);
    step();
    chk("s1_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("s1_rsp_tag",   32'(bus.rsp_tag), 'hAAAA);
    chk("s1_rsp_ce",    32'(cam_chip_enable), 0);
    tag_drv = 16'h5555;
    step();
    chk("s1_hold_valid", 32'(bus.rsp_valid), 1);
    chk("s1_hold_tag",   32'(bus.rsp_tag), 'hAAAA);
    bus.rsp_ready = 1'b1;
    step();
    chk("s1_taken", 32'(bus.rsp_valid), 0);

    // chained, accumulating search
    send(3'd2, 1'b1, 1'b1, 1'b0, 10'h001, 4'h0, 2'd0, 2'd0, 16'h0, 16'h1111);
    step();
    chk("s2_acc", 32'(cam_acc_en), 1);
    chk("s2_chain_tag", 32'(cam_tag_in), 'hAAAA);
    step();
    step();
    chk("s2_rsp", 32'({bus.rsp_valid, bus.rsp_tag}), 'h15555);
    step();

    // masked update that never completes: err after 16 WAIT_WR cycles
    send(3'd1, 1'b0, 1'b0, 1'b0, 10'h3FF, 4'hF, 2'd3, 2'd3, 16'h00FF, 16'hF0F0);
    step();
    chk("to_upd", 32'({cam_update_signal, cam_operation_mode}), 'h9);
    step();
    repeat (15) step();
    chk("to_early_valid", 32'(bus.rsp_valid), 0);
    chk("to_upd_held", 32'(cam_update_signal), 1);
    step();
    chk("to_rsp", 32'({bus.rsp_valid, bus.rsp_err, bus.rsp_tag}), 'h30000);
    step();

    // illegal op: straight to an error response, CAM pins untouched
    send(3'd5, 1'b0, 1'b0, 1'b0, 10'h0, 4'h0, 2'd0, 2'd0, 16'h0, 16'h0);
    step();
    chk("ill_rsp", 32'({bus.rsp_valid, bus.rsp_err, bus.rsp_tag}), 'h30000);
    chk("ill_ce", 32'(cam_chip_enable), 0);
    chk("ill_mode_untouched", 32'(cam_operation_mode), 1);
    step();
    chk("ill_taken", 32'(bus.rsp_valid), 0);

    // writes and errors left last_tag at the previous search result
    tag_drv = 16'h1234;
    send(3'd2, 1'b0, 1'b1, 1'b0, 10'h002, 4'h0, 2'd0, 2'd0, 16'h0, 16'h0);
    step();
    chk("s3_chain_tag", 32'(cam_tag_in), 'h5555);
    step();
    step();
    chk("s3_rsp_tag", 32'(bus.rsp_tag), 'h1234);
    step();

    // fill the queue behind a stalled response, then drain in order
    bus.rsp_ready = 1'b0;
    tag_mode = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      send(3'd2, 1'b0, 1'b0, 1'b0, 10'(k), 4'h0, 2'd0, 2'd0, 16'h0, 16'h0);
    end
    chk("q_full_ready", 32'(bus.cmd_ready), 0);
    bus.cmd_cmp_addr = 10'd6;
    bus.cmd_valid = 1'b1;
    step();
    chk("q_full_hold", 32'(bus.cmd_ready), 0);
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int r = 1; r <= 5; r++) begin
      int n;
      n = 0;
      while (!bus.rsp_valid && n < 20) begin
        step();
        n++;
      end
      chk("q_rsp_valid", 32'(bus.rsp_valid), 1);
      chk("q_rsp_tag", 32'(bus.rsp_tag), 32'(r));
      step();
    end
    chk("q_busy_done", 32'(busy), 0);
    chk("q_no_extra", 32'(bus.rsp_valid), 0);

    // reset while a write waits with another queued: everything dropped
    tag_mode = 1'b0;
    send(3'd0, 1'b0, 1'b0, 1'b1, 10'h0AA, 4'h1, 2'd1, 2'd1, 16'hBEEF, 16'h0);
    send(3'd0, 1'b0, 1'b0, 1'b0, 10'h0BB, 4'h2, 2'd2, 2'd2, 16'h1111, 16'h0);
    step();
    step();
    chk("mr_ce_before", 32'(cam_chip_enable), 1);
    rst = 1'b0;
    #1;
    chk("mr_ce", 32'(cam_chip_enable), 0);
    chk("mr_pins", 32'({cam_data_in, cam_cmp_addr, cam_operation_mode}), 0);
    chk("mr_rsp", 32'(bus.rsp_valid), 0);
    chk("mr_ready", 32'(bus.cmd_ready), 0);
    chk("mr_busy", 32'(busy), 0);
    cam_write_done = 1'b1;
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mr_no_rsp", 32'({bus.rsp_valid, cam_chip_enable}), 0);
    end
    chk("mr_idle", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
